// File: rtl/opsum_collector.sv
// opsum_collector: buffers tagged psum beats from the PE array and writes them word by word
// to the output buffer from a programmed base. Define OPSUM_RELU_EN to clamp negative words to 0.
module opsum_collector #(
  parameter int PSUM_DATA_SIZE = 32,
  parameter int OPSUM_NUM      = 4,
  parameter int ROW_LEN        = 4,
  parameter int ID_LEN         = 5,
  parameter int ADDR_W         = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   base_addr,
  input  logic [15:0]                         total_beats,
  input  logic                                opsum_enable,
  output logic                                opsum_ready,
  input  logic [ROW_LEN-1:0]                  opsum_row_tag,
  input  logic [ID_LEN-1:0]                   opsum_col_tag,
  input  logic [PSUM_DATA_SIZE*OPSUM_NUM-1:0] opsum_value,
  output logic                                mem_we,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [PSUM_DATA_SIZE-1:0]           mem_wdata,
  input  logic                                mem_grant,
  output logic [ROW_LEN-1:0]                  last_row_tag,
  output logic [ID_LEN-1:0]                   last_col_tag,
  output logic                                busy,
  output logic                                done
);
  localparam int BEAT_W = PSUM_DATA_SIZE * OPSUM_NUM;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int K_W    = (OPSUM_NUM > 1) ? $clog2(OPSUM_NUM) : 1;
  localparam int BYTES  = PSUM_DATA_SIZE / 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [15:0]       total_q;
  logic [15:0]       acc_cnt;
  logic [15:0]       wr_beat;
  logic [K_W-1:0]    k;
  logic [BEAT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic                             launch, push, pop, grant_fire, last_grant, k_last;
  logic signed [PSUM_DATA_SIZE-1:0] head_elem;
  logic [ADDR_W-1:0]                word_idx;

  function automatic logic [PSUM_DATA_SIZE-1:0] relu_clamp(input logic signed [PSUM_DATA_SIZE-1:0] x);
`ifdef OPSUM_RELU_EN
    relu_clamp = (x < 0) ? '0 : x;
`else
    relu_clamp = x;
`endif
  endfunction

  assign launch      = (state == IDLE) && start && (total_beats != 16'd0);
  assign opsum_ready = (state == RUN) && (fifo_count < CNT_W'(FIFO_DEPTH)) && (acc_cnt < total_q);
  assign push        = opsum_enable && opsum_ready;
  assign mem_we      = (state == RUN) && (fifo_count != '0);
  assign grant_fire  = mem_we && mem_grant;
  assign k_last      = (k == K_W'(OPSUM_NUM - 1));
  assign pop         = grant_fire && k_last;
  assign last_grant  = pop && (wr_beat == total_q - 16'd1);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // Write path: head element select, optional clamp, address generation (wraps at ADDR_W)
  assign head_elem = fifo_mem[rd_ptr][k*PSUM_DATA_SIZE +: PSUM_DATA_SIZE];
  assign word_idx  = ADDR_W'(wr_beat) * ADDR_W'(OPSUM_NUM) + ADDR_W'(k);
  assign mem_addr  = mem_we ? (base_q + word_idx * ADDR_W'(BYTES)) : '0;
  assign mem_wdata = mem_we ? relu_clamp(head_elem) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (total_beats == 16'd0) ? DONE : RUN;
      RUN:     if (last_grant) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      acc_cnt      <= '0;
      wr_beat      <= '0;
      k            <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      last_row_tag <= '0;
      last_col_tag <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        acc_cnt    <= '0;
        wr_beat    <= '0;
        k          <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) begin
          wr_ptr       <= wr_ptr + PTR_W'(1);
          acc_cnt      <= acc_cnt + 16'd1;
          last_row_tag <= opsum_row_tag;
          last_col_tag <= opsum_col_tag;
        end
        if (grant_fire) begin
          if (k_last) begin
            k       <= '0;
            rd_ptr  <= rd_ptr + PTR_W'(1);
            wr_beat <= wr_beat + 16'd1;
          end else begin
            k <= k + K_W'(1);
          end
        end
        if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
        else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // Payload storage carries no reset; it is only read behind fifo_count
  always_ff @(posedge clk) begin
    if (launch) begin
      base_q  <= base_addr;
      total_q <= total_beats;
    end
    if (push) fifo_mem[wr_ptr] <= opsum_value;
  end

endmodule

// File: doc/opsum_collector.md
# opsum_collector

Receiving end of the PE array's opsum stream. It accepts tagged OPSUM_NUM-wide psum beats from `PEArray` over the enable/ready handshake and buffers them in a small FIFO. It then serializes each beat into 32-bit word writes to the output buffer at consecutive addresses from a programmed base. It sits between the PE array output port and the output-buffer SRAM write port, and signals completion to the layer controller.

## Interface
- `PSUM_DATA_SIZE`, 32, bits per psum element (the memory word width equals this value)
- `OPSUM_NUM`, 4, psum elements per beat
- `ROW_LEN`, 4, row tag width
- `ID_LEN`, 5, column tag width
- `ADDR_W`, 32, byte address width
- `FIFO_DEPTH`, 4, beat FIFO entries (power of two, ≥2)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; latches `base_addr` and `total_beats`
- `base_addr`  in  ADDR_W  byte address of the first word
- `total_beats`  in  16  number of beats to collect
- `opsum_enable`  in  1  PE array has a valid beat
- `opsum_ready`  out  1  collector accepts the beat
- `opsum_row_tag`  in  ROW_LEN  row tag of the beat
- `opsum_col_tag`  in  ID_LEN  column tag of the beat
- `opsum_value`  in  PSUM_DATA_SIZE*OPSUM_NUM  psums; element k is `[k*PSUM_DATA_SIZE +: PSUM_DATA_SIZE]`
- `mem_we`  out  1  write request
- `mem_addr`  out  ADDR_W  write byte address
- `mem_wdata`  out  PSUM_DATA_SIZE  write data
- `mem_grant`  in  1  write accepted this cycle
- `last_row_tag`  out  ROW_LEN  tag of the most recently accepted beat
- `last_col_tag`  out  ID_LEN  tag of the most recently accepted beat
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start` with `total_beats`≠0. The block latches base and total, and clears `acc_cnt` (accepted beats), `wr_beat` (written beats) and `k` (element index).
- IDLE → DONE on `start` with `total_beats`==0.
- `start` is ignored outside IDLE.
- Beat acceptance: `opsum_ready` = (RUN) & (fifo_count < FIFO_DEPTH) & (acc_cnt < total). This is combinational and does not depend on `opsum_enable`.
- A beat is accepted on `opsum_enable & opsum_ready`. On acceptance the block pushes the value, increments `acc_cnt`, and updates `last_*_tag`.
- Writer: while the FIFO is non-empty in RUN, `mem_we`=1.
  - `mem_wdata` = element `k` of the head entry.
  - `mem_addr` = base + (wr_beat*OPSUM_NUM + k)*(PSUM_DATA_SIZE/8), computed modulo 2^ADDR_W (wraps).
  - Each request is held stable until `mem_grant`.
  - On grant, `k` increments. On grant with k==OPSUM_NUM-1, the head is popped, `k` returns to 0 and `wr_beat` increments.
- Push and pop in the same cycle are legal; `fifo_count` is then unchanged. Push on a full FIFO cannot occur because ready is low.
- RUN → DONE on the grant of the last element of beat total-1.
- DONE: `done`=1 for exactly one cycle, then the state returns to IDLE.
- Reset mid-operation: FIFO and counters are cleared and the state is IDLE. Partially written beats are abandoned and no `done` is issued.

## Timing
- Reset values:
  - `opsum_ready`, `mem_we`, `busy`, `done` = 0
  - `mem_addr`, `mem_wdata`, `last_row_tag`, `last_col_tag` = 0
- `opsum_ready` can first be high in the cycle after `start`.
- The FIFO is registered: the first `mem_we` for a beat occurs in the cycle after its acceptance; there is no bypass.
- With `mem_grant` held at 1, each beat occupies exactly OPSUM_NUM consecutive write cycles.
- `done` rises in the cycle after the final grant.
- `mem_addr` and `mem_wdata` are 0 whenever `mem_we`=0.

## Configuration
- `OPSUM_RELU_EN`: when defined, each element is clamped to 0 if negative (MSB set) before it is placed on `mem_wdata`.
- When undefined, elements are written unmodified as raw two's complement.
- The clamp is combinational on the write path and adds no latency.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs are 0; release, with no `start` → `opsum_ready` stays 0.
- Basic: start with base=0x100, total=2, grant=1, then send two beats with values 0x4_3_2_1 and 0x8_7_6_5 (element 0 is the low word) → writes of 1,2,3,4,5,6,7,8 to 0x100,0x104,…,0x11C on 8 consecutive cycles, then `done` pulses once and `busy` drops.
- Backpressure: total=6, grant=0, enable held → exactly 4 beats accepted, then ready stays 0 and `mem_we`/`mem_addr`=0x100 held stable; raise grant → all 24 writes complete in order and `done` pulses.
- Zero length: start with total=0 → `done` on the next cycle, no `mem_we`, ready never high; a `start` pulsed during RUN is ignored (base unchanged).
- Reset mid-operation: assert `rst` after 5 of 8 writes → outputs return to reset values immediately; a new start with base=0x200, total=1 → writes begin at 0x200.
- Macro: element 0 = 0xFFFFFFF6 → written as 0x00000000 with `OPSUM_RELU_EN` defined and as 0xFFFFFFF6 without it; element 1 = 0x0000000A is written as 0x0000000A in both builds.
